eq_gain_ctrl: RTL and testbench

- Consumes the 32-bit equalizer word shifted in over SPI from the MCU and its `load` framing signal.
- Moves the word into the system clock domain (HSOSC clk) and unpacks it into per-band gain targets.
- Ramps the live per-band gains toward the targets one step per audio sample, so gain changes produce no zipper noise.
- Drives the gain bus read by the downstream equalizer filter bank.

---
 rtl/eq_gain_ctrl.sv | 120 ++++++++++++
 tb/tb_eq_gain_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ctrl.sv
// Equalizer gain controller: brings the SPI-loaded EQ word into the clk domain
// and ramps the live per-band gains toward it one code step per audio sample.
module eq_gain_ctrl #(
  parameter int NBANDS       = 8,
  parameter int GW           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEFAULT_GAIN = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBANDS*GW-1:0]   eq_word,
  input  logic                   sample_strobe,
  output logic [NBANDS*GW-1:0]   gain,
  output logic                   busy,
  output logic                   gain_updated
);

  localparam int W = NBANDS * GW;
  localparam logic [GW-1:0] DEF_CODE = GW'(DEFAULT_GAIN);
  localparam logic [W-1:0]  DEF_WORD = {NBANDS{DEF_CODE}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RAMP    = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [W-1:0]     target;
  logic [W-1:0]     stepped;
  logic [SYNC_STAGES-1:0] load_sync;
  logic             load_hist;
  logic             load_fall;
  logic             take_word;
  logic             take_step;
  logic             set_updated;

  // load synchronizer plus one history flop for edge detection.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample their inputs from the same clock edge regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_sync <= '0;
      load_hist <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      load_hist <= load_sync[SYNC_STAGES-1];
    end
  end

  assign load_fall = load_hist & ~load_sync[SYNC_STAGES-1];

  // One code step of every band toward its target, all bands in parallel.
  always_comb begin
    stepped = gain;
    for (int i = 0; i < NBANDS; i++) begin
      if (gain[i*GW +: GW] < target[i*GW +: GW])
        stepped[i*GW +: GW] = gain[i*GW +: GW] + GW'(1);
      else if (gain[i*GW +: GW] > target[i*GW +: GW])
        stepped[i*GW +: GW] = gain[i*GW +: GW] - GW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    take_word   = 1'b0;
    take_step   = 1'b0;
    set_updated = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_fall) next_state = CAPTURE;
      end
      CAPTURE: begin
        // eq_word has been stable for SYNC_STAGES cycles by now.
        take_word = 1'b1;
        if (eq_word == gain) begin
          next_state  = IDLE;
          set_updated = 1'b1;
        end else begin
          next_state = RAMP;
        end
      end
      RAMP: begin
        if (load_fall) begin
          next_state = CAPTURE;
        end else if (sample_strobe) begin
          take_step = 1'b1;
          if (stepped == target) begin
            next_state  = IDLE;
            set_updated = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target       <= DEF_WORD;
      gain         <= DEF_WORD;
      gain_updated <= 1'b0;
    end else begin
      gain_updated <= set_updated;
      if (take_word) target <= eq_word;
      if (take_step) gain   <= stepped;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl: directed loads and strobes push expected
// gain steps and completions; a negedge monitor pops and compares them.
module tb_eq_gain_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] eq_word;
  logic        sample_strobe;
  logic [31:0] gain;
  logic        busy;
  logic        gain_updated;

  int passed = 0;
  int total  = 0;

  logic [31:0] step_q[$];
  logic [31:0] done_q[$];
  logic        mon_en   = 1'b0;
  logic [31:0] prev_gain;
  logic        upd_prev = 1'b0;

  eq_gain_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .eq_word      (eq_word),
    .sample_strobe(sample_strobe),
    .gain         (gain),
    .busy         (busy),
    .gain_updated (gain_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    $display("FAIL %s: unexpected event with gain 0x%08h, expected none", name, act);
  endtask

  // Monitor: every gain change and every gain_updated pulse consumes one
  // expectation; anything the stimulus did not announce is an error.
  always @(negedge clk) begin
    if (mon_en) begin
      if (upd_prev) check("upd_single_cycle", {31'd0, gain_updated}, 32'd0);
      if (gain !== prev_gain) begin
        if (step_q.size() > 0) check("gain_step", gain, step_q.pop_front());
        else unexpected("gain_step", gain);
        prev_gain = gain;
      end
      if (gain_updated) begin
        if (done_q.size() > 0) check("done_gain", gain, done_q.pop_front());
        else unexpected("done_gain", gain);
      end
      upd_prev = gain_updated;
    end
  end

  task automatic load_word(input logic [31:0] w);
    @(posedge clk); #1;
    eq_word = w;
    load    = 1'b1;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic strobe();
    @(posedge clk); #1 sample_strobe = 1'b1;
    @(posedge clk); #1 sample_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] gain_before);
    if (gain_before !== 32'h8888_8888) step_q.push_back(32'h8888_8888);
    #2 reset = 1'b1;
    #1;
    check("reset_async_gain", gain, 32'h8888_8888);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_upd", {31'd0, gain_updated}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; eq_word = '0; sample_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // 1: reset state, strobes without a load do nothing
    check("init_gain", gain, 32'h8888_8888);
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_upd", {31'd0, gain_updated}, 32'd0);
    prev_gain = gain;
    mon_en    = 1'b1;
    repeat (16) strobe();
    check("idle_strobes_gain", gain, 32'h8888_8888);

    // 2: two-step ramp to 0xAAAAAAAA, busy latency from load fall
    step_q.push_back(32'h9999_9999);
    step_q.push_back(32'hAAAA_AAAA);
    done_q.push_back(32'hAAAA_AAAA);
    load_word(32'hAAAA_AAAA);
    repeat (2) @(posedge clk);
    #1 check("busy_not_yet", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("busy_after_fall", {31'd0, busy}, 32'd1);
    strobe();
    check("ramp2_s1", gain, 32'h9999_9999);
    strobe();
    check("ramp2_s2", gain, 32'hAAAA_AAAA);
    check("ramp2_idle", {31'd0, busy}, 32'd0);

    // 3: mixed rise/fall/hold, 8 strobes from default
    do_reset(32'hAAAA_AAAA);
    begin
      logic [31:0] tbl [8];
      tbl = '{32'h7989_8987, 32'h6A8A_8A86, 32'h5B8B_8B85, 32'h4C8C_8C84,
              32'h3D8D_8D83, 32'h2E8E_8E82, 32'h1F8F_8F81, 32'h0F8F_8F80};
      foreach (tbl[k]) step_q.push_back(tbl[k]);
      done_q.push_back(32'h0F8F_8F80);
      load_word(32'h0F8F_8F80);
      repeat (5) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        strobe();
        if (k == 6) check("mixed_busy_s7", {31'd0, busy}, 32'd1);
      end
      check("mixed_final", gain, 32'h0F8F_8F80);
      check("mixed_idle", {31'd0, busy}, 32'd0);
    end

    // 4: retarget mid-ramp
    do_reset(32'h0F8F_8F80);
    step_q.push_back(32'h9999_9999);
    step_q.push_back(32'hAAAA_AAAA);
    step_q.push_back(32'hBBBB_BBBB);
    load_word(32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    repeat (3) strobe();
    check("mid_gain", gain, 32'hBBBB_BBBB);
    step_q.push_back(32'hAAAA_AAAA);
    step_q.push_back(32'h9999_9999);
    done_q.push_back(32'h9999_9999);
    load_word(32'h9999_9999);
    repeat (5) @(posedge clk);
    check("retarget_hold", gain, 32'hBBBB_BBBB);
    strobe();
    strobe();
    check("retarget_final", gain, 32'h9999_9999);

    // 5: load of a word equal to current gain
    done_q.push_back(32'h9999_9999);
    load_word(32'h9999_9999);
    repeat (8) @(posedge clk);
    #1;
    check("equal_gain", gain, 32'h9999_9999);
    check("equal_idle", {31'd0, busy}, 32'd0);

    // 6: asynchronous reset during a ramp, then a one-step load
    step_q.push_back(32'hAAAA_AAAA);
    step_q.push_back(32'hBBBB_BBBB);
    step_q.push_back(32'hCCCC_CCCC);
    load_word(32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    repeat (3) strobe();
    check("pre_reset_gain", gain, 32'hCCCC_CCCC);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    do_reset(32'hCCCC_CCCC);
    step_q.push_back(32'h9999_9999);
    done_q.push_back(32'h9999_9999);
    load_word(32'h9999_9999);
    repeat (5) @(posedge clk);
    strobe();
    check("post_reset_gain", gain, 32'h9999_9999);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    repeat (10) @(posedge clk);
    #1;
    check("step_q_drained", step_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
